// File: rtl/breath_if.sv
// breath_if: control inputs and level/wrap outputs of the breath sequencer.
interface breath_if #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4
);
  logic                      enable;
  logic [1:0]                mode;
  logic [CHANNELS*WIDTH-1:0] level;
  logic [CHANNELS-1:0]       wrap;

  modport master (
    output enable, mode,
    input  level, wrap
  );

  modport slave (
    input  enable, mode,
    output level, wrap
  );
endinterface

// File: rtl/breath_sequencer.sv
// breath_sequencer: multi-channel staggered brightness ramps
// (triangle, sawtooth, hold) stepped by a shared prescaler.
module breath_sequencer #(
  parameter int WIDTH       = 8,
  parameter int CHANNELS    = 4,
  parameter int STEP_TIME   = 16,
  parameter int MIN_LEVEL   = 0,
  parameter int MAX_LEVEL   = 2**WIDTH-1,
  parameter int PHASE_STEPS = 0
) (
  input logic     clk,
  input logic     reset,
  breath_if.slave bus
);
  localparam int PW   = (STEP_TIME > 1) ? $clog2(STEP_TIME) : 1;
  localparam int DMAX = (CHANNELS-1)*PHASE_STEPS;
  localparam int DW   = (DMAX > 0) ? $clog2(DMAX+1) : 1;

  typedef logic [WIDTH-1:0] lvl_t;
  typedef enum logic [1:0] {
    M_TRI  = 2'd0,
    M_SAW  = 2'd1,
    M_HOLD = 2'd2,
    M_RSV  = 2'd3
  } mode_e;
  typedef enum logic {D_UP, D_DN} dir_e;

  localparam lvl_t          LMIN = lvl_t'(MIN_LEVEL);
  localparam lvl_t          LMAX = lvl_t'(MAX_LEVEL);
  localparam logic [PW-1:0] PTOP = PW'(STEP_TIME-1);

  logic [PW-1:0] r_cnt, w_cnt;
  logic          w_tick;
  mode_e         w_mode_in;

  lvl_t          r_lvl  [CHANNELS];
  lvl_t          w_lvl  [CHANNELS];
  dir_e          r_dir  [CHANNELS];
  dir_e          w_dir  [CHANNELS];
  mode_e         r_mode [CHANNELS];
  mode_e         w_mode [CHANNELS];
  logic [DW-1:0] r_dly  [CHANNELS];
  logic [DW-1:0] w_dly  [CHANNELS];
  logic [CHANNELS-1:0] r_wrap, w_wrap;

  assign w_mode_in = mode_e'(bus.mode);
  assign w_tick    = bus.enable && (r_cnt == PTOP);

  always_comb begin
    w_cnt  = r_cnt;
    w_wrap = '0;
    if (bus.enable) w_cnt = w_tick ? '0 : r_cnt + 1'b1;
    for (int k = 0; k < CHANNELS; k++) begin
      w_lvl[k]  = r_lvl[k];
      w_dir[k]  = r_dir[k];
      w_mode[k] = r_mode[k];
      w_dly[k]  = r_dly[k];
      if (w_tick) begin
        if (r_dly[k] != '0) begin
          w_dly[k] = r_dly[k] - 1'b1;
          w_lvl[k] = LMIN;
        end else begin
          unique case (r_mode[k])
            M_TRI: begin
              if (r_dir[k] == D_UP) begin
                w_lvl[k] = r_lvl[k] + 1'b1;
                if (r_lvl[k] == LMAX - 1'b1) w_dir[k] = D_DN;
              end else begin
                w_lvl[k] = r_lvl[k] - 1'b1;
                if (r_lvl[k] == LMIN + 1'b1) begin
                  w_dir[k]  = D_UP;
                  w_wrap[k] = 1'b1;
                  w_mode[k] = w_mode_in;
                end
              end
            end
            M_SAW: begin
              if (r_lvl[k] == LMAX) begin
                w_lvl[k]  = LMIN;
                w_dir[k]  = D_UP;
                w_wrap[k] = 1'b1;
                w_mode[k] = w_mode_in;
              end else begin
                w_lvl[k] = r_lvl[k] + 1'b1;
              end
            end
            M_HOLD, M_RSV: begin
              w_lvl[k]  = LMIN;
              w_dir[k]  = D_UP;
              w_mode[k] = w_mode_in;
            end
            default: ;
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt  <= '0;
      r_wrap <= '0;
      for (int k = 0; k < CHANNELS; k++) begin
        r_lvl[k]  <= LMIN;
        r_dir[k]  <= D_UP;
        r_mode[k] <= w_mode_in;
        r_dly[k]  <= DW'(k*PHASE_STEPS);
      end
    end else begin
      r_cnt  <= w_cnt;
      r_wrap <= w_wrap;
      for (int k = 0; k < CHANNELS; k++) begin
        r_lvl[k]  <= w_lvl[k];
        r_dir[k]  <= w_dir[k];
        r_mode[k] <= w_mode[k];
        r_dly[k]  <= w_dly[k];
      end
    end
  end

  for (genvar k = 0; k < CHANNELS; k++) begin : g_out
    assign bus.level[k*WIDTH +: WIDTH] = r_lvl[k];
  end
  assign bus.wrap = r_wrap;
endmodule

// File: tb/tb_breath_sequencer.sv
// tb_breath_sequencer: randomized stimulus, waveform-position reference
// model feeding a scoreboard queue, popped by a per-cycle monitor.
module tb_breath_sequencer;
  localparam int W  = 5;
  localparam int C  = 3;
  localparam int ST = 4;
  localparam int MN = 2;
  localparam int MX = 9;
  localparam int PS = 2;
  localparam int R  = MX - MN;
  localparam int NV = 3000;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  breath_if #(.WIDTH(W), .CHANNELS(C)) bus ();

  breath_sequencer #(
    .WIDTH(W), .CHANNELS(C), .STEP_TIME(ST),
    .MIN_LEVEL(MN), .MAX_LEVEL(MX), .PHASE_STEPS(PS)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  logic [C*W+C-1:0] sb_q[$];
  int m_cnt;
  int m_dly [C];
  int m_pos [C];
  int m_am  [C];
  logic [C-1:0] m_wrap;
  int vectors = 0;
  int miscompares = 0;
  bit started = 0;

  function automatic int lvl_of(int k);
    if (m_dly[k] > 0 || m_am[k] >= 2) return MN;
    if (m_am[k] == 0)
      return MN + ((m_pos[k] <= R) ? m_pos[k] : 2*R - m_pos[k]);
    return MN + m_pos[k];
  endfunction

  task automatic model_step(input logic rst, input logic en,
                            input logic [1:0] md);
    logic tick;
    logic [C*W-1:0] lv;
    m_wrap = '0;
    if (rst) begin
      m_cnt = 0;
      for (int k = 0; k < C; k++) begin
        m_dly[k] = k*PS;
        m_pos[k] = 0;
        m_am[k]  = int'(md);
      end
    end else begin
      tick = en && (m_cnt == ST-1);
      if (en) m_cnt = tick ? 0 : m_cnt + 1;
      if (tick) begin
        for (int k = 0; k < C; k++) begin
          if (m_dly[k] > 0) m_dly[k]--;
          else if (m_am[k] >= 2) m_am[k] = int'(md);
          else begin
            m_pos[k] = (m_pos[k] + 1) % ((m_am[k] == 0) ? 2*R : R+1);
            if (m_pos[k] == 0) begin
              m_wrap[k] = 1'b1;
              m_am[k]   = int'(md);
            end
          end
        end
      end
    end
    for (int k = 0; k < C; k++) lv[k*W +: W] = W'(lvl_of(k));
    sb_q.push_back({lv, m_wrap});
  endtask

  initial begin
    logic       rst;
    logic       en;
    logic [1:0] md;
    reset = 1'b1;
    bus.enable = 1'b0;
    bus.mode = 2'd0;
    md = 2'd0;
    repeat (2) @(posedge clk);
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      if (i < 2) rst = 1'b1;
      else if (i >= 800) rst = ($urandom_range(0, 399) == 0);
      else rst = 1'b0;
      if (i >= 100 && i <= 106) en = 1'b0;
      else if (i >= 800) en = ($urandom_range(0, 5) != 0);
      else en = 1'b1;
      if (i >= 300 && $urandom_range(0, 39) == 0)
        md = 2'($urandom_range(0, 3));
      if (i == 1200) md = 2'd2;
      if (i == 1300) md = 2'd0;
      reset = rst;
      bus.enable = en;
      bus.mode = md;
      model_step(rst, en, md);
      started = 1'b1;
    end
  end

  initial begin
    logic [C*W+C-1:0] exp_v;
    logic [C*W+C-1:0] got_v;
    wait (started);
    for (int i = 0; i < NV; i++) begin
      @(posedge clk);
      #1;
      vectors++;
      if (sb_q.size() == 0) begin
        miscompares++;
        $display("FAIL sb_empty cycle %0d: no expected entry", i);
      end else begin
        exp_v = sb_q.pop_front();
        got_v = {bus.level, bus.wrap};
        if (got_v !== exp_v) begin
          miscompares++;
          $display("FAIL cycle %0d level got %h exp %h wrap got %b exp %b",
                   i, got_v[C*W+C-1:C], exp_v[C*W+C-1:C],
                   got_v[C-1:0], exp_v[C-1:0]);
        end
      end
    end
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/breath_sequencer.md
# breath_sequencer

Multi-channel, parametrised brightness ramp generator. It drives per-channel duty-cycle levels into the PWM generators. Each channel steps its level by ±1 once every STEP_TIME enabled cycles, using a selectable waveform (triangle, sawtooth, hold). Channels are staggered by a fixed number of steps after reset to give a chase effect, and each channel emits a wrap pulse at every period boundary.

## Interface
- WIDTH, 8: bits per channel level.
- CHANNELS, 4: number of independent channels.
- STEP_TIME, 16: enabled clk cycles per level step; must be ≥ 1.
- MIN_LEVEL, 0: lower bound of the ramp.
- MAX_LEVEL, 2**WIDTH-1: upper bound of the ramp. Must satisfy MIN_LEVEL < MAX_LEVEL ≤ 2**WIDTH-1.
- PHASE_STEPS, 0: extra steps that channel k holds at MIN after reset, multiplied by k.

- clk  in  1  system clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  when 0, freezes the prescaler, the levels, the delay counters and the mode registers.
- mode  in  2  requested waveform: 0 triangle, 1 sawtooth, 2 hold, 3 hold (reserved).
- level  out  CHANNELS*WIDTH  packed channel levels; channel k is level[k*WIDTH +: WIDTH]; registered.
- wrap  out  CHANNELS  one-cycle pulse per channel at period end; registered.

## Operation
- Prescaler: a single shared counter, $clog2(STEP_TIME) bits wide (1 bit minimum).
  - It counts 0..STEP_TIME-1 while enable=1.
  - tick = enable && count==STEP_TIME-1. The counter returns to 0 on tick.
- Per-channel state: level, dir (up/down), active mode, and a delay counter.
  - The delay counter is sized to hold (CHANNELS-1)*PHASE_STEPS.
- Reset applies to every channel:
  - level=MIN_LEVEL, dir=up, wrap=0, prescaler=0.
  - Delay counter = k*PHASE_STEPS.
  - Active mode = mode input.
- On tick, a channel whose delay counter is nonzero decrements it and holds level at MIN_LEVEL.
- Triangle mode, on tick:
  - Up: level+1. Reaching MAX_LEVEL sets dir=down.
  - Down: level-1. Reaching MIN_LEVEL sets dir=up, pulses wrap, and resamples mode.
  - Sequence: MIN, MIN+1 … MAX, MAX-1 … MIN+1, then MIN again. Each bound is held for exactly one step.
  - Period = 2*(MAX_LEVEL-MIN_LEVEL)*STEP_TIME enabled cycles.
- Sawtooth mode, on tick:
  - level+1, except at MAX_LEVEL, where the next value is MIN_LEVEL. That transition pulses wrap and resamples mode.
  - Period = (MAX_LEVEL-MIN_LEVEL+1)*STEP_TIME.
- Hold mode (2 or 3):
  - Level is forced to MIN_LEVEL and dir to up; no wrap pulses.
  - Mode is resampled on every tick, so leaving hold takes effect on the next tick.
  - The ramp starts from MIN_LEVEL one step after leaving hold.
- A change on the mode input mid-period is ignored until that channel's next wrap (or next tick while in hold).
- Arithmetic never leaves [MIN_LEVEL, MAX_LEVEL]; there is no modular wrap-around of the WIDTH-bit value.
- Channels differ only in their delay; after delay expiry every channel is identical to channel 0 shifted by k*PHASE_STEPS steps.

## Timing
- Outputs update on the clk edge on which tick is true.
  - The new level is visible in the following cycle.
  - wrap is high for exactly that one cycle, coincident with level first showing MIN_LEVEL.
- Cycle 0 is the first edge with reset=0 and enable=1 throughout. Channel 0 shows MIN_LEVEL for exactly STEP_TIME cycles, then MIN_LEVEL+1.
- Channel k leaves MIN_LEVEL after (k*PHASE_STEPS+1)*STEP_TIME cycles.
- enable=0 for N cycles stretches the current step by exactly N cycles; no output changes during the stall.
- A wrap pulse is never extended by enable=0: it lasts exactly one clk cycle.
- reset asserted mid-ramp: level=MIN_LEVEL and wrap=0 in the cycle after the reset edge. Delay counters reload, and timing restarts as for cycle 0.
- STEP_TIME=1: the level changes every enabled cycle, and wrap pulses can occur in consecutive periods with no gap cycle.

## Test plan
- WIDTH=5, CHANNELS=1, STEP_TIME=16, MIN=0, MAX=15, triangle:
  - Level must match the golden triangle 0→15→0, each step 16 cycles.
  - wrap every 480 cycles, first at cycle 480.
- Sawtooth with MIN=2, MAX=5, STEP_TIME=3:
  - Level is 2,3,4,5,2… with each value held 3 cycles.
  - wrap is high on the cycle level returns to 2, every 12 cycles.
- CHANNELS=3, PHASE_STEPS=2, STEP_TIME=4, triangle:
  - ch0 leaves MIN at cycle 4, ch1 at cycle 12, ch2 at cycle 20.
  - Thereafter ch1 equals ch0 delayed by 8 cycles.
- enable=0 for 7 cycles mid-step:
  - level and wrap frozen; that step lasts STEP_TIME+7 cycles; all later edges shift by 7.
- Mode switch triangle→sawtooth at a mid-ramp level:
  - Triangle continues to its wrap, then sawtooth begins.
  - Mode=2: level holds MIN with wrap=0. Returning to mode 0 starts the ramp one step later.
- reset pulse for 1 cycle while levels are nonzero:
  - Next cycle all levels are MIN_LEVEL and wrap=0.
  - Staggered start repeats exactly as after power-on.
